// File: rtl/alu_pkg.sv
// Shared types and latency bounds for the ALU bank: command/response encodings
// and the per-channel FSM state type.
package alu_pkg;

    typedef enum logic [1:0] {
        NOP      = 2'd0,
        ADD      = 2'd1,
        MULTIPLY = 2'd2,
        AND      = 2'd3
    } command_names_t;

    // Encoding 3 is reserved and never driven.
    typedef enum logic [1:0] {
        NO_RESPONSE = 2'd0,
        SUCCESS     = 2'd1,
        OVERFLOW    = 2'd2
    } response_names_t;

    typedef enum logic {
        IDLE    = 1'b0,
        EXECUTE = 1'b1
    } channel_state_t;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 255;
    localparam int LAT_WIDTH   = 8;

    function automatic bit latency_ok(input int latency);
        return (latency >= LATENCY_MIN) && (latency <= LATENCY_MAX);
    endfunction

endpackage

// File: rtl/alu_channel.sv
// One ALU channel: IDLE/EXECUTE FSM with a per-command latency counter, a
// single-cycle response pulse and a sticky dropped-command flag.
module alu_channel
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADD_LATENCY = 3,
    parameter int MUL_LATENCY = 5,
    parameter int AND_LATENCY = 3,
    parameter bit SATURATE    = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            command,
    input  logic [DATA_WIDTH-1:0] data1,
    input  logic [DATA_WIDTH-1:0] data2,
    output logic                  busy,
    output logic [1:0]            response,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  dropped
);

    if (!latency_ok(ADD_LATENCY) || !latency_ok(MUL_LATENCY) || !latency_ok(AND_LATENCY)) begin : g_bad_latency
        $error("alu_channel: every latency parameter must lie in 1..255");
    end

    command_names_t        cmd;
    channel_state_t        state, next_state;
    command_names_t        op_q;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [LAT_WIDTH-1:0]  count, load_value;
    logic                  accept, finish;
    response_names_t       resp_q, result_resp;
    logic [DATA_WIDTH-1:0] result_data, raw;
    logic [DATA_WIDTH:0]   sum;
    logic [2*DATA_WIDTH-1:0] product;
    logic                  overflow;

    assign cmd      = command_names_t'(command);
    assign busy     = (state == EXECUTE);
    assign response = resp_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (cmd != NOP) begin
                accept     = 1'b1;
                next_state = EXECUTE;
            end
            EXECUTE: if (count == '0) begin
                finish     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The counter holds the number of remaining edges before the response edge.
    always_comb begin
        load_value = LAT_WIDTH'(AND_LATENCY - 1);
        case (cmd)
            ADD:      load_value = LAT_WIDTH'(ADD_LATENCY - 1);
            MULTIPLY: load_value = LAT_WIDTH'(MUL_LATENCY - 1);
            default:  load_value = LAT_WIDTH'(AND_LATENCY - 1);
        endcase
    end

    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        product  = {{DATA_WIDTH{1'b0}}, a_q} * {{DATA_WIDTH{1'b0}}, b_q};
        overflow = 1'b0;
        raw      = a_q & b_q;
        case (op_q)
            ADD: begin
                overflow = sum[DATA_WIDTH];
                raw      = sum[DATA_WIDTH-1:0];
            end
            MULTIPLY: begin
                overflow = |product[2*DATA_WIDTH-1:DATA_WIDTH];
                raw      = product[DATA_WIDTH-1:0];
            end
            default: begin
                overflow = 1'b0;
                raw      = a_q & b_q;
            end
        endcase
        result_resp = overflow ? OVERFLOW : SUCCESS;
        result_data = (overflow && SATURATE) ? {DATA_WIDTH{1'b1}} : raw;
    end

    // NOTE: state is updated with non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            op_q    <= NOP;
            a_q     <= '0;
            b_q     <= '0;
            count   <= '0;
            resp_q  <= NO_RESPONSE;
            result  <= '0;
            dropped <= 1'b0;
        end else begin
            state  <= next_state;
            resp_q <= NO_RESPONSE;
            if (accept) begin
                op_q  <= cmd;
                a_q   <= data1;
                b_q   <= data2;
                count <= load_value;
            end else if (state == EXECUTE && count != '0) begin
                count <= count - LAT_WIDTH'(1);
            end
            if (finish) begin
                resp_q <= result_resp;
                result <= result_data;
            end
            if (state == EXECUTE && cmd != NOP) begin
                dropped <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_bank_array.sv
// Bank of N_CHANNELS fully independent ALU channels sharing only clock and reset.
module alu_bank_array
    import alu_pkg::*;
#(
    parameter int N_CHANNELS  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ADD_LATENCY = 3,
    parameter int MUL_LATENCY = 5,
    parameter int AND_LATENCY = 3,
    parameter bit SATURATE    = 1'b0
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [N_CHANNELS-1:0][1:0]            in_command,
    input  logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] in_data1,
    input  logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] in_data2,
    output logic [N_CHANNELS-1:0]                 busy,
    output logic [N_CHANNELS-1:0][1:0]            out_response,
    output logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] out_data,
    output logic [N_CHANNELS-1:0]                 dropped
);

    if (N_CHANNELS < 1 || N_CHANNELS > 16 || DATA_WIDTH < 8 || DATA_WIDTH > 64) begin : g_bad_shape
        $error("alu_bank_array: N_CHANNELS must be 1..16 and DATA_WIDTH 8..64");
    end

    for (genvar ch = 0; ch < N_CHANNELS; ch++) begin : g_channel
        alu_channel #(
            .DATA_WIDTH  (DATA_WIDTH),
            .ADD_LATENCY (ADD_LATENCY),
            .MUL_LATENCY (MUL_LATENCY),
            .AND_LATENCY (AND_LATENCY),
            .SATURATE    (SATURATE)
        ) u_channel (
            .clock    (clock),
            .reset    (reset),
            .command  (in_command[ch]),
            .data1    (in_data1[ch]),
            .data2    (in_data2[ch]),
            .busy     (busy[ch]),
            .response (out_response[ch]),
            .result   (out_data[ch]),
            .dropped  (dropped[ch])
        );
    end

endmodule

// File: doc/alu_bank_array.md
ALU_BANK_ARRAY -- requirements
Module: alu_bank_array

Interface
REQ-001 Parameter N_CHANNELS, default 4, number of independent ALU channels (1..16).
REQ-002 Parameter DATA_WIDTH, default 32, operand and result width (8..64).
REQ-003 Parameter ADD_LATENCY, default 3, ADD cycles from command sample to response (1..255).
REQ-004 Parameter MUL_LATENCY, default 5, MULTIPLY latency (1..255).
REQ-005 Parameter AND_LATENCY, default 3, AND latency (1..255).
REQ-006 Parameter SATURATE, default 0; when 1, overflowing results clamp to all-ones.
REQ-007 clock  input  1  sole clock; all state updates on posedge.
REQ-008 reset  input  1  one clock; reset is synchronous and active-low.
REQ-009 in_command  input  N_CHANNELS x 2  per-channel command_names_t: NOP, ADD, MULTIPLY, AND.
REQ-010 in_data1  input  N_CHANNELS x DATA_WIDTH  per-channel operand 1.
REQ-011 in_data2  input  N_CHANNELS x DATA_WIDTH  per-channel operand 2.
REQ-012 busy  output  N_CHANNELS  channel executing; commands ignored.
REQ-013 out_response  output  N_CHANNELS x 2  per-channel response_names_t: NO_RESPONSE, SUCCESS, OVERFLOW.
REQ-014 out_data  output  N_CHANNELS x DATA_WIDTH  per-channel result.
REQ-015 dropped  output  N_CHANNELS  sticky flag: a non-NOP command arrived while busy.

Function
REQ-016 Each channel SHALL run an independent FSM with states IDLE and EXECUTE; channels share no state.
REQ-017 In IDLE, a non-NOP in_command at posedge k SHALL capture command and operands, load the latency counter, and enter EXECUTE.
REQ-018 busy SHALL be 1 exactly while in EXECUTE, i.e. after edge k through edge k+L, L = that command's latency.
REQ-019 At edge k+L the channel SHALL return to IDLE and drive out_response/out_data for exactly one cycle (k+L to k+L+1).
REQ-020 out_response SHALL be NO_RESPONSE in every other cycle; out_data SHALL hold its last result until the next response.
REQ-021 A non-NOP command while busy SHALL be ignored (captured operands unchanged) and SHALL set dropped[ch] until reset.
REQ-022 A command present during the response cycle (IDLE) SHALL be accepted at the following edge; back-to-back throughput is one op per L+1 cycles.
REQ-023 ADD: DATA_WIDTH+1-bit sum; carry out -> OVERFLOW, else SUCCESS.
REQ-024 MULTIPLY: 2*DATA_WIDTH-bit product; any nonzero upper half -> OVERFLOW, else SUCCESS.
REQ-025 AND: bitwise; always SUCCESS.
REQ-026 On OVERFLOW, out_data SHALL be the low DATA_WIDTH bits when SATURATE=0, all-ones when SATURATE=1.
REQ-027 Response encoding value 3 SHALL never be driven.
REQ-028 Illegal latency parameters (0 or >255) SHALL trigger an elaboration-time error.

Reset
REQ-029 reset=0 at a posedge SHALL force every channel to IDLE, busy=0, out_response=NO_RESPONSE, out_data=0, dropped=0, counters=0.
REQ-030 Reset mid-EXECUTE SHALL abort the operation with no response emitted after reset release.
REQ-031 The first command is accepted at the first posedge with reset=1.

Structure
REQ-032 command_names_t, response_names_t and latency bounds SHALL reside in shared package alu_pkg.
REQ-033 Per-channel logic SHALL be sub-module alu_channel, instantiated N_CHANNELS times via generate.

Verification
REQ-034 Ch0 ADD 0xFFFFFFFF+0x00000001 at edge k -> OVERFLOW, out_data 0x00000000 in cycle k+3 only; with SATURATE=1 -> 0xFFFFFFFF.
REQ-035 Ch1 MULTIPLY 3*7 -> SUCCESS 0x00000015 at k+5; MULTIPLY 0x00010000*0x00010000 -> OVERFLOW, data 0x00000000.
REQ-036 All 4 channels: AND 0xF0F0F0F0 & 0xFF00FF00 same edge -> all SUCCESS 0xF000F000 at k+3 simultaneously.
REQ-037 Ch2 ADD at k, MULTIPLY at k+1 -> ADD response at k+3 with original operands, dropped[2]=1, no second response.
REQ-038 Ch3 MULTIPLY at k, reset=0 at k+2 -> busy=0, no response; dropped and out_data zero.
REQ-039 Random latencies/commands for 500 cycles per channel -> response exactly L cycles after accept, data matches reference model.
